sha_msg_schedule: RTL and testbench



---
 rtl/sha_msg_schedule.sv | 113 +++++++++++
 tb/tb_sha_msg_schedule.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_schedule.sv
// SHA-256/SHA-512 message schedule: loads a 16-word block, then streams W0..W(ROUNDS-1).
// Optional abort input is enabled by defining SHA_SCHED_ABORT_EN.
module sha_msg_schedule #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SHA_SCHED_ABORT_EN
    input  logic              abort,
`endif
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [WORD_W-1:0] w,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    output logic [6:0]        w_idx
);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
            $error("sha_msg_schedule: WORD_W must be 32 or 64");
        end
        if (ROUNDS < 16 || ROUNDS > 80) begin : g_bad_rounds
            $error("sha_msg_schedule: ROUNDS must be in 16..80");
        end
    endgenerate

    // Rotate/shift amounts chosen once so every shift stays below WORD_W.
    localparam int unsigned S0_R1 = (WORD_W == 64) ? 1  : 7;
    localparam int unsigned S0_R2 = (WORD_W == 64) ? 8  : 18;
    localparam int unsigned S0_SH = (WORD_W == 64) ? 7  : 3;
    localparam int unsigned S1_R1 = (WORD_W == 64) ? 19 : 17;
    localparam int unsigned S1_R2 = (WORD_W == 64) ? 61 : 19;
    localparam int unsigned S1_SH = (WORD_W == 64) ? 6  : 10;
    localparam logic [6:0]  LAST_T = 7'(ROUNDS - 1);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t                   state, state_nxt;
    logic [15:0][WORD_W-1:0]  window;
    logic [3:0]               load_cnt;
    logic [6:0]               t;
    logic                     din_xfer, w_xfer, last_t, clr;
    logic [WORD_W-1:0]        new_word;

`ifdef SHA_SCHED_ABORT_EN
    assign clr = abort;
`else
    assign clr = 1'b0;
`endif

    // window[k] holds W(t+k); slot 15 receives W(t+16) on each emitted word.
    assign new_word = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
    assign last_t   = (t == LAST_T);

    always_comb begin
        state_nxt = state;
        din_ready = (state != STREAM);
        w_valid   = (state == STREAM);
        din_xfer  = din_valid & din_ready;
        w_xfer    = w_valid & w_ready;
        w         = w_valid ? window[0] : '0;
        w_idx     = w_valid ? t : 7'd0;
        w_last    = w_valid & last_t;
        case (state)
            IDLE:    if (din_xfer) state_nxt = LOAD;
            LOAD:    if (din_xfer && load_cnt == 4'd15) state_nxt = STREAM;
            STREAM:  if (w_xfer && last_t) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            window   <= '0;
            load_cnt <= 4'd0;
            t        <= 7'd0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                window   <= '0;
                load_cnt <= 4'd0;
                t        <= 7'd0;
            end else if (din_xfer) begin
                // load_cnt wraps to 0 on the 16th word, ready for the next block
                window   <= {din, window[15:1]};
                load_cnt <= load_cnt + 4'd1;
            end else if (w_xfer) begin
                window <= {new_word, window[15:1]};
                t      <= last_t ? 7'd0 : t + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Randomized self-checking bench: SHA-256 (32/64) and SHA-512 (64/80) schedule instances
// checked every cycle against an array-based schedule model.
module tb_sha_msg_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] din0, w0;
    logic        din_valid0, din_ready0, w_valid0, w_ready0, w_last0;
    logic [6:0]  w_idx0;
    logic [63:0] din1, w1;
    logic        din_valid1, din_ready1, w_valid1, w_ready1, w_last1;
    logic [6:0]  w_idx1;
    logic        ab0, ab1;
`ifdef SHA_SCHED_ABORT_EN
    logic        abort0, abort1;
    assign ab0 = abort0;
    assign ab1 = abort1;
`else
    assign ab0 = 1'b0;
    assign ab1 = 1'b0;
`endif

    sha_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut0 (
        .clk(clk), .rst(rst),
`ifdef SHA_SCHED_ABORT_EN
        .abort(abort0),
`endif
        .din(din0), .din_valid(din_valid0), .din_ready(din_ready0),
        .w(w0), .w_valid(w_valid0), .w_ready(w_ready0), .w_last(w_last0), .w_idx(w_idx0));

    sha_msg_schedule #(.WORD_W(64), .ROUNDS(80)) dut1 (
        .clk(clk), .rst(rst),
`ifdef SHA_SCHED_ABORT_EN
        .abort(abort1),
`endif
        .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
        .w(w1), .w_valid(w_valid1), .w_ready(w_ready1), .w_last(w_last1), .w_idx(w_idx1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rounds_of(input int d);
        return (d == 0) ? 64 : 80;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int d);
        logic [31:0] a;
        a = x[31:0];
        if (d == 0) return {32'h0, (a >> n) | (a << (32 - n))};
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] sig0(input logic [63:0] x, input int d);
        if (d == 0) return rotr(x, 7, 0) ^ rotr(x, 18, 0) ^ (x >> 3);
        return rotr(x, 1, 1) ^ rotr(x, 8, 1) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] sig1(input logic [63:0] x, input int d);
        if (d == 0) return rotr(x, 17, 0) ^ rotr(x, 19, 0) ^ (x >> 10);
        return rotr(x, 19, 1) ^ rotr(x, 61, 1) ^ (x >> 6);
    endfunction

    int          loaded[2];
    int          idx[2];
    int          done[2];
    int          lastcnt[2];
    bit          prev_stall[2];
    logic [63:0] prev_w[2];
    logic [63:0] blk[2][16];
    logic [63:0] ws[2][80];
    logic [63:0] obs[2][80];

    task automatic build_sched(input int d);
        logic [63:0] m;
        m = (d == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
        for (int k = 0; k < 16; k++) ws[d][k] = blk[d][k];
        for (int k = 16; k < rounds_of(d); k++)
            ws[d][k] = (sig1(ws[d][k-2], d) + ws[d][k-7] + sig0(ws[d][k-15], d) + ws[d][k-16]) & m;
    endtask

    task automatic step(input int d, input logic r, input logic ab,
                        input logic [63:0] dn, input logic dv, input logic dr,
                        input logic [63:0] wv, input logic vv, input logic wr,
                        input logic lst, input logic [6:0] wi);
        bit strm;
        strm = (loaded[d] == 16);
        if (r) begin
            chk($sformatf("d%0d rst w_valid", d), 64'(vv), 64'd0);
            chk($sformatf("d%0d rst din_ready", d), 64'(dr), 64'd1);
            chk($sformatf("d%0d rst w", d), wv, 64'd0);
            chk($sformatf("d%0d rst w_idx", d), 64'(wi), 64'd0);
            chk($sformatf("d%0d rst w_last", d), 64'(lst), 64'd0);
            loaded[d] = 0; idx[d] = 0; lastcnt[d] = 0; prev_stall[d] = 0;
            return;
        end
        chk($sformatf("d%0d din_ready", d), 64'(dr), 64'(!strm));
        chk($sformatf("d%0d w_valid", d), 64'(vv), 64'(strm));
        if (strm) begin
            chk($sformatf("d%0d w[%0d]", d, idx[d]), wv, ws[d][idx[d]]);
            chk($sformatf("d%0d w_idx", d), 64'(wi), 64'(idx[d]));
            chk($sformatf("d%0d w_last", d), 64'(lst), 64'(idx[d] == rounds_of(d) - 1));
            if (prev_stall[d]) chk($sformatf("d%0d stall hold", d), wv, prev_w[d]);
        end else begin
            chk($sformatf("d%0d idle w", d), wv, 64'd0);
            chk($sformatf("d%0d idle w_idx", d), 64'(wi), 64'd0);
            chk($sformatf("d%0d idle w_last", d), 64'(lst), 64'd0);
        end
        prev_stall[d] = strm && !wr;
        prev_w[d]     = wv;
        if (ab) begin
            loaded[d] = 0; idx[d] = 0; lastcnt[d] = 0; prev_stall[d] = 0;
            return;
        end
        if (!strm && dv) begin
            blk[d][loaded[d]] = dn;
            loaded[d]++;
            if (loaded[d] == 16) build_sched(d);
        end else if (strm && wr) begin
            obs[d][idx[d]] = wv;
            if (lst) lastcnt[d]++;
            idx[d]++;
            if (idx[d] == rounds_of(d)) begin
                chk($sformatf("d%0d w_last pulses", d), 64'(lastcnt[d]), 64'd1);
                done[d]++;
                loaded[d] = 0; idx[d] = 0; lastcnt[d] = 0;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            loaded[d] = 0; idx[d] = 0; done[d] = 0; lastcnt[d] = 0; prev_stall[d] = 0; prev_w[d] = '0;
        end
    end

    always @(negedge clk) begin
        step(0, rst, ab0, {32'h0, din0}, din_valid0, din_ready0, {32'h0, w0}, w_valid0, w_ready0, w_last0, w_idx0);
        step(1, rst, ab1, din1, din_valid1, din_ready1, w1, w_valid1, w_ready1, w_last1, w_idx1);
    end

    // ---------------- stimulus ----------------
    bit rr[2];
    always @(posedge clk) begin
        #1;
        w_ready0 = rr[0] ? 1'($urandom_range(0, 1)) : 1'b1;
        w_ready1 = rr[1] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [63:0] stim[16];

    task automatic set_abc(input int d);
        for (int k = 0; k < 16; k++) stim[k] = '0;
        stim[0]  = (d == 0) ? 64'h6162_6380 : 64'h6162_6380_0000_0000;
        stim[15] = 64'h18;
    endtask

    task automatic set_rand(input int d);
        for (int k = 0; k < 16; k++)
            stim[k] = (d == 0) ? {32'h0, $urandom} : {$urandom, $urandom};
    endtask

    task automatic send_words(input int d, input int n, input bit gaps);
        int  i;
        int  guard;
        bit  v, acc;
        i = 0; guard = 0;
        while (i < n) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (d == 0) begin din0 = v ? stim[i][31:0] : $urandom; din_valid0 = v; end
            else        begin din1 = v ? stim[i] : {$urandom, $urandom}; din_valid1 = v; end
            @(negedge clk);
            acc = v && ((d == 0) ? din_ready0 : din_ready1);
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
            if (guard > 2000) begin
                checks++; errors++;
                $display("FAIL d%0d din accept timeout: got %0d words expected %0d", d, i, n);
                break;
            end
        end
        if (d == 0) din_valid0 = 1'b0; else din_valid1 = 1'b0;
    endtask

    task automatic wait_done(input int d, input int target);
        int guard;
        guard = 0;
        while (done[d] < target) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 1000) begin
                checks++; errors++;
                $display("FAIL d%0d block done timeout: got %0d expected %0d", d, done[d], target);
                break;
            end
        end
    endtask

    initial begin
        int guard;
        int base;
        rst = 1'b1;
        din0 = '0; din_valid0 = 1'b0; w_ready0 = 1'b1;
        din1 = '0; din_valid1 = 1'b0; w_ready1 = 1'b1;
        rr[0] = 1'b0; rr[1] = 1'b0;
`ifdef SHA_SCHED_ABORT_EN
        abort0 = 1'b0; abort1 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // SHA-256 "abc"
        set_abc(0);
        send_words(0, 16, 1'b0);
        wait_done(0, 1);
        chk("abc256 W0",  obs[0][0],  64'h6162_6380);
        chk("abc256 W16", obs[0][16], 64'h6162_6380);
        chk("abc256 W17", obs[0][17], 64'h000F_0000);
        chk("abc256 W18", obs[0][18], 64'h7DA8_6405);
        chk("abc256 W19", obs[0][19], 64'h6000_03C6);
        chk("abc256 W63", obs[0][63], 64'h12B1_EDEB);
        chk("model W17",  ws[0][17],  64'h000F_0000);
        chk("model W63",  ws[0][63],  64'h12B1_EDEB);

        // backpressure on the same block
        rr[0] = 1'b1;
        send_words(0, 16, 1'b0);
        wait_done(0, 2);
        rr[0] = 1'b0;
        chk("bp W63", obs[0][63], 64'h12B1_EDEB);

        // back-to-back blocks with din_valid held high
        send_words(0, 16, 1'b0);
        send_words(0, 16, 1'b0);
        wait_done(0, 4);
        chk("b2b W16", obs[0][16], 64'h6162_6380);

        // random blocks, random din gaps, random backpressure
        for (int b = 0; b < 3; b++) begin
            set_rand(0);
            rr[0] = 1'b1;
            send_words(0, 16, 1'b1);
            wait_done(0, 5 + b);
        end
        rr[0] = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of streaming
        set_abc(0);
        base = done[0];
        send_words(0, 16, 1'b0);
        guard = 0;
        while (!(w_valid0 && w_idx0 == 7'd20) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach w_idx 20", 64'(w_idx0), 64'd20);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst w_valid", 64'(w_valid0), 64'd0);
        chk("post-rst din_ready", 64'(din_ready0), 64'd1);
        @(posedge clk); #1;
        send_words(0, 16, 1'b0);
        wait_done(0, base + 1);
        chk("post-rst W16", obs[0][16], 64'h6162_6380);
        chk("post-rst block count", 64'(done[0]), 64'(base + 1));

        // SHA-512 "abc", then a random 512 block with backpressure
        set_abc(1);
        send_words(1, 16, 1'b0);
        wait_done(1, 1);
        chk("abc512 W16", obs[1][16], 64'h6162_6380_0000_0000);
        chk("abc512 W17", obs[1][17], ws[1][17]);
        set_rand(1);
        rr[1] = 1'b1;
        send_words(1, 16, 1'b1);
        wait_done(1, 2);
        rr[1] = 1'b0;

`ifdef SHA_SCHED_ABORT_EN
        // abort while loading word 7
        set_abc(0);
        base = done[0];
        for (int k = 0; k < 7; k++) stim[k] = {32'h0, $urandom};
        send_words(0, 7, 1'b0);
        din0 = 32'hDEAD_BEEF; din_valid0 = 1'b1; abort0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0; din_valid0 = 1'b0;
        @(negedge clk);
        chk("abort din_ready", 64'(din_ready0), 64'd1);
        chk("abort w_valid", 64'(w_valid0), 64'd0);
        @(posedge clk); #1;
        set_abc(0);
        send_words(0, 16, 1'b0);
        wait_done(0, base + 1);
        chk("abort W16", obs[0][16], 64'h6162_6380);
        chk("abort W63", obs[0][63], 64'h12B1_EDEB);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
